// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and opcode constants for the pipelined mini-ALU (alu_pipe) and
// its iterative multiplier (alu_mul_seq). The two low opcode bits keep the
// legacy AND/OR/SUB/ADD encoding of the old combinational 4-bit ALU.
// Contents:
//   OPC_*   : 3-bit opcode constants, used by the decoder and by benches
//   op_t    : enumerated opcode type built from those constants
//   state_t : control state of alu_pipe (IDLE, MUL)
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] OPC_AND = 3'b000;
    localparam logic [2:0] OPC_OR  = 3'b001;
    localparam logic [2:0] OPC_SUB = 3'b010;
    localparam logic [2:0] OPC_ADD = 3'b011;
    localparam logic [2:0] OPC_XOR = 3'b100;
    localparam logic [2:0] OPC_SLL = 3'b101;
    localparam logic [2:0] OPC_SRL = 3'b110;
    localparam logic [2:0] OPC_MUL = 3'b111;

    typedef enum logic [2:0] {
        OP_AND = OPC_AND,
        OP_OR  = OPC_OR,
        OP_SUB = OPC_SUB,
        OP_ADD = OPC_ADD,
        OP_XOR = OPC_XOR,
        OP_SLL = OPC_SLL,
        OP_SRL = OPC_SRL,
        OP_MUL = OPC_MUL
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
// Unsigned shift-add multiplier, one partial product per clock. A start pulse
// captures the operands; WIDTH clock edges later the full 2*WIDTH product is
// ready. done and product are combinational so the caller can register the
// final product on the same edge that performs the last iteration.
// Only instantiated when ALU_MUL_EN is defined.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset (aborts any iteration)
//   start    in   capture a and b, begin iterating
//   a, b     in   WIDTH-bit unsigned operands
//   done     out  high during the cycle whose edge completes the last step
//   product  out  2*WIDTH-bit product, valid while done is high
// -----------------------------------------------------------------------------
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   count;
    logic               busy;

    // The multiplier LSB selects whether the shifted multiplicand is added in
    // this step; acc_next is what acc becomes after the current iteration.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    assign done    = busy && (count == CNT_W'(1));
    assign product = acc_next;

    // Iteration registers: load on start, then shift the multiplicand left and
    // the multiplier right each cycle while counting WIDTH steps down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            count  <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            acc    <= '0;
            mplier <= b;
            count  <= CNT_W'(WIDTH);
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Handshaked, parametrised ALU between operand issue and writeback. Logic ops,
// add/sub, XOR and logical shifts complete in one cycle; MUL (when compiled in)
// runs through alu_mul_seq for WIDTH cycles. Results and flags sit in an output
// register held stable until the consumer takes them.
// Build option: define ALU_MUL_EN to include the multiplier. Without it, op 111
// completes in one cycle with result 0, flag_z 1 and err 1; result_hi is tied 0.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (op, in_a, in_b sampled on accept)
//   op                    3-bit opcode (see alu_pkg)
//   in_a, in_b            WIDTH-bit operands, A op B
//   out_valid / out_ready output handshake
//   result, result_hi     result (MUL: low/high product halves)
//   flag_c/z/n/v          carry, zero, negative, signed overflow
//   err                   illegal opcode
// -----------------------------------------------------------------------------
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic             err
);

    localparam int SHAMT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH:0] ONE_EXT = 1;

    op_t                op_e;
    logic               accept;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_sum;
    logic [WIDTH:0]     sll_ext;
    logic [WIDTH:0]     srl_ext;
    logic [SHAMT_W-1:0] shamt;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic               alu_err;

    logic               load;
    logic [WIDTH-1:0]   ld_res;
    logic               ld_c;
    logic               ld_v;
    logic               ld_err;

    assign op_e   = op_t'(op);
    assign accept = in_valid && in_ready;

    // The shifters carry one extra bit so the last bit shifted out lands in a
    // fixed position; amounts beyond WIDTH shift everything out and give zero.
    assign add_sum = {1'b0, in_a} + {1'b0, in_b};
    assign sub_sum = {1'b0, in_a} + {1'b0, ~in_b} + ONE_EXT;
    assign shamt   = in_b[SHAMT_W-1:0];
    assign sll_ext = {1'b0, in_a} << shamt;
    assign srl_ext = {in_a, 1'b0} >> shamt;

    // Single-cycle datapath. For SUB the carry is the no-borrow bit (A >= B).
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (op_e)
            OP_AND: alu_res = in_a & in_b;
            OP_OR:  alu_res = in_a | in_b;
            OP_XOR: alu_res = in_a ^ in_b;
            OP_ADD: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_c   = add_sum[WIDTH];
                alu_v   = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                          (add_sum[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_sum[WIDTH-1:0];
                alu_c   = sub_sum[WIDTH];
                alu_v   = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                          (sub_sum[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SLL: begin
                alu_res = sll_ext[WIDTH-1:0];
                alu_c   = sll_ext[WIDTH];
            end
            OP_SRL: begin
                alu_res = srl_ext[WIDTH:1];
                alu_c   = srl_ext[0];
            end
            OP_MUL: begin
`ifdef ALU_MUL_EN
                alu_err = 1'b0;
`else
                alu_err = 1'b1;
`endif
            end
            default: alu_err = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    state_t             state;
    state_t             state_next;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH-1:0]   ld_hi;
    logic [WIDTH-1:0]   hi_q;

    assign mul_start = accept && (op_e == OP_MUL);
    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign result_hi = hi_q;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (in_a),
        .b       (in_b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Control state register: IDLE accepts work, MUL waits for the multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus selection of what the output register loads. Accepting
    // a MUL pops any old result but loads nothing until the product is done,
    // so the register is always free when the multiplier finishes.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        ld_res     = alu_res;
        ld_hi      = '0;
        ld_c       = alu_c;
        ld_v       = alu_v;
        ld_err     = alu_err;
        case (state)
            IDLE: begin
                if (mul_start) begin
                    state_next = MUL;
                end else if (accept) begin
                    load = 1'b1;
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_next = IDLE;
                    load       = 1'b1;
                    ld_res     = mul_product[WIDTH-1:0];
                    ld_hi      = mul_product[2*WIDTH-1:WIDTH];
                    ld_c       = |mul_product[2*WIDTH-1:WIDTH];
                    ld_v       = 1'b0;
                    ld_err     = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // High product half; every non-MUL load writes zero here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
        end else if (load) begin
            hi_q <= ld_hi;
        end
    end
`else
    assign in_ready  = !out_valid || out_ready;
    assign result_hi = '0;

    // Every accepted op, including the illegal 111, completes in one cycle.
    always_comb begin
        load   = accept;
        ld_res = alu_res;
        ld_c   = alu_c;
        ld_v   = alu_v;
        ld_err = alu_err;
    end
`endif

    // Output register: a load wins over a pop, so a simultaneous pop and
    // accept replaces the old result without a bubble. Otherwise the contents
    // stay put while the consumer stalls, and out_valid drops once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_v    <= 1'b0;
            err       <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            result    <= ld_res;
            flag_c    <= ld_c;
            flag_z    <= (ld_res == '0);
            flag_n    <= ld_res[WIDTH-1];
            flag_v    <= ld_v;
            err       <= ld_err;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
// Self-checking bench for alu_pipe at WIDTH=8. A directed vector table and a
// set of random vectors (expected values from a small arithmetic model) are
// driven through the input handshake; expected records go into a scoreboard
// queue and are compared when the DUT hands each result out, together with the
// number of edges between accept and first appearance of out_valid. Hand
// sequences cover back-pressure, MUL timing and reset in the middle of a MUL.
// Honours ALU_MUL_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int WIDTH    = 8;
    localparam int MAX_WAIT = 60;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [7:0] hi;
        logic       c;
        logic       z;
        logic       n;
        logic       ovf;
        logic       err;
    } vec_t;

    typedef struct {
        vec_t vec;
        int   acc_cyc;
        int   lat;
    } sb_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             flag_c;
    logic             flag_z;
    logic             flag_n;
    logic             flag_v;
    logic             err;

    sb_t  sbq[$];
    bit   headSeen     = 1'b0;
    int   cyc          = 0;
    int   compareCount = 0;
    int   failCount    = 0;
    vec_t tbl[11];

    alu_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_v    (flag_v),
        .err       (err)
    );

    // Free-running clock and an edge counter used for latency checks.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [20:0] packExp(input vec_t v);
        return {v.res, v.hi, v.c, v.z, v.n, v.ovf, v.err};
    endfunction

    function automatic logic [20:0] packDut();
        return {result, result_hi, flag_c, flag_z, flag_n, flag_v, err};
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
        compareCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Independent reference: plain integer arithmetic on the operands.
    function automatic vec_t model(input logic [2:0] o, input logic [7:0] a,
                                   input logic [7:0] b);
        vec_t r;
        int   ua, ub, sa, sb, s, sh;
        r.op = o; r.a = a; r.b = b;
        r.res = 8'h00; r.hi = 8'h00; r.c = 1'b0; r.ovf = 1'b0; r.err = 1'b0;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        sh = int'(b[2:0]);
        case (o)
            OPC_AND: r.res = a & b;
            OPC_OR:  r.res = a | b;
            OPC_XOR: r.res = a ^ b;
            OPC_ADD: begin
                s = ua + ub; r.res = s[7:0]; r.c = (s > 255);
                s = sa + sb; r.ovf = (s > 127) || (s < -128);
            end
            OPC_SUB: begin
                s = ua - ub; r.res = s[7:0]; r.c = (ua >= ub);
                s = sa - sb; r.ovf = (s > 127) || (s < -128);
            end
            OPC_SLL: begin
                s = ua << sh; r.res = s[7:0];
                r.c = (sh == 0) ? 1'b0 : s[8];
            end
            OPC_SRL: begin
                s = ua >> sh; r.res = s[7:0];
                if (sh != 0) begin
                    s = ua >> (sh - 1); r.c = s[0];
                end
            end
            default: begin
                if (MUL_EN) begin
                    s = ua * ub; r.res = s[7:0]; r.hi = s[15:8];
                    r.c = (r.hi != 8'h00);
                end else begin
                    r.err = 1'b1;
                end
            end
        endcase
        r.z = (r.res == 8'h00);
        r.n = r.res[7];
        return r;
    endfunction

    // Drive one op, wait (bounded) for acceptance, optionally record it.
    task automatic applyStimulus(input vec_t v, input bit track);
        int waited;
        sb_t e;
        in_valid = 1'b1;
        op       = v.op;
        in_a     = v.a;
        in_b     = v.b;
        waited   = 0;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            waited++;
            if (waited > MAX_WAIT) begin
                compareCount++;
                failCount++;
                $display("[TB] FAIL accept_timeout: op %0d not accepted in %0d cycles", v.op, MAX_WAIT);
                in_valid = 1'b0;
                return;
            end
        end
        if (track) begin
            e.vec     = v;
            e.acc_cyc = cyc + 1;
            e.lat     = (v.op == OPC_MUL && MUL_EN) ? WIDTH : 0;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Compare the result leaving the DUT with the oldest expected record.
    task automatic checkOutput();
        sb_t e;
        if (sbq.size() == 0) begin
            compareCount++;
            failCount++;
            $display("[TB] FAIL unexpected_output: got 0x%0h, expected no output", packDut());
        end else begin
            e = sbq.pop_front();
            checkValue($sformatf("result_op%0d_a%02h_b%02h", e.vec.op, e.vec.a, e.vec.b),
                       32'(packDut()), 32'(packExp(e.vec)));
        end
    endtask

    // Monitor: latency when a result first appears, value when it is consumed.
    always @(negedge clk) begin
        if (rst_n && out_valid && sbq.size() > 0 && !headSeen) begin
            headSeen = 1'b1;
            checkValue("latency", cyc - sbq[0].acc_cyc, sbq[0].lat);
        end
        if (rst_n && out_valid && out_ready) begin
            checkOutput();
            headSeen = 1'b0;
        end
    end

    task automatic drain();
        int waited;
        waited = 0;
        while (sbq.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (sbq.size() != 0) begin
            compareCount++;
            failCount++;
            $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", sbq.size());
            sbq.delete();
            headSeen = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        int   bad;

        tbl[0]  = '{OPC_ADD, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{OPC_SUB, 8'h80, 8'h01, 8'h7F, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{OPC_SUB, 8'h01, 8'h02, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{OPC_SLL, 8'h81, 8'h01, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{OPC_SRL, 8'h81, 8'h03, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{OPC_AND, 8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{OPC_OR,  8'hF0, 8'h3C, 8'hFC, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{OPC_XOR, 8'hF0, 8'h3C, 8'hCC, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{OPC_SLL, 8'h81, 8'h00, 8'h81, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{OPC_SRL, 8'h80, 8'h07, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{OPC_ADD, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 3'b000;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkValue("reset_outputs", 32'({out_valid, packDut()}), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkValue("in_ready_after_reset", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;

        $display("[TB] directed vectors");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(tbl[i], 1'b1);
        end
        drain();
        @(negedge clk);
        checkValue("out_valid_drops", 32'(out_valid), 32'h0);
        @(posedge clk);
        #1;

        $display("[TB] back-pressure");
        out_ready = 1'b0;
        applyStimulus('{OPC_ADD, 8'h12, 8'h34, 8'h46, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);
        in_valid = 1'b1;
        op       = OPC_OR;
        in_a     = 8'h0F;
        in_b     = 8'hA0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkValue("bp_in_ready_low", 32'(in_ready), 32'h0);
            checkValue("bp_result_held", 32'({out_valid, result}), 32'h146);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        applyStimulus('{OPC_OR, 8'h0F, 8'hA0, 8'hAF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}, 1'b1);
        drain();

        $display("[TB] multiply");
        v = '{OPC_MUL, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        if (!MUL_EN) v = '{OPC_MUL, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        applyStimulus(v, 1'b1);
        in_a = 8'h00;
        in_b = 8'h00;
        op   = OPC_AND;
`ifdef ALU_MUL_EN
        bad = 0;
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b0) bad++;
        end
        checkValue("mul_in_ready_low_cycles", 32'(bad), 32'h0);
`endif
        drain();

        $display("[TB] reset during multiply");
        out_ready = 1'b0;
        applyStimulus('{OPC_MUL, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkValue("reset_mid_mul", 32'({out_valid, packDut()}), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        applyStimulus('{OPC_ADD, 8'h05, 8'h03, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);
        drain();

        $display("[TB] random vectors");
        for (int i = 0; i < 24; i++) begin
            logic [2:0] ro;
            logic [7:0] ra;
            logic [7:0] rb;
            ro = 3'($urandom_range(0, 7));
            ra = 8'($urandom);
            rb = 8'($urandom);
            applyStimulus(model(ro, ra, rb), 1'b1);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the 4-bit combinational mini-ALU. It keeps the legacy 2-bit operation encoding (AND/OR/SUB/ADD) as the low codes of a 3-bit opcode, and adds XOR, logical shifts and an optional iterative multiplier. Results and flags are registered behind a valid/ready interface. It sits between the operand-issue logic and the writeback stage of the lab datapath.

## Interface
- WIDTH, 8, operand/result width; minimum 2.
- SHAMT_W, $clog2(WIDTH), derived; shift-amount field width.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  block can accept this cycle.
- op  in  3  000 AND, 001 OR, 010 SUB, 011 ADD, 100 XOR, 101 SLL, 110 SRL, 111 MUL.
- in_a, in_b  in  WIDTH  operands (A op B).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  result (MUL: low half).
- result_hi  out  WIDTH  MUL high half; 0 for all other ops.
- flag_c, flag_z, flag_n, flag_v  out  1  carry, zero, negative, signed overflow.
- err  out  1  illegal opcode (MUL when compiled out).

## Operation
- Transfer on input when in_valid && in_ready; on output when out_valid && out_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This gives back-to-back throughput of 1 op per cycle for single-cycle ops.
- States:
  - IDLE → IDLE on a single-cycle op (result register loaded).
  - IDLE → MUL on an accepted MUL.
  - MUL → IDLE after WIDTH iterations, loading the output register.
- SUB: A + ~B + 1, WIDTH+1-bit internal sum.
- SLL/SRL: shift by in_b[SHAMT_W-1:0], zero fill. An amount ≥ WIDTH (non-power-of-2 WIDTH) yields 0.
- MUL: unsigned shift-add, one partial product per cycle, full 2·WIDTH product split as {result_hi, result}.
- flag_z = (result==0), low half only.
- flag_n = result[WIDTH-1].
- flag_c, by op:
  - ADD: carry out.
  - SUB: no-borrow, i.e. A ≥ B unsigned.
  - SLL/SRL: last bit shifted out (0 for shift amount 0).
  - MUL: |result_hi.
  - Otherwise: 0.
- flag_v: two's-complement overflow for ADD/SUB; 0 otherwise.
- The output register is held stable while out_valid && !out_ready.
- Inputs are sampled only on the accepting edge. Later changes to in_a, in_b or op during MUL have no effect.

## Timing
- Reset, asynchronous: state=IDLE, out_valid=0, result=0, result_hi=0, all flags=0, err=0. in_ready=1 after reset deasserts.
- Single-cycle ops: accepted at edge N → out_valid=1 after edge N (latency 1).
- MUL: accepted at edge N → in_ready=0 for WIDTH cycles → out_valid=1 after edge N+WIDTH.
- Simultaneous output pop and input accept in one cycle: the old result leaves and the new one loads. No bubble, no loss.
- out_valid falls after the consuming edge when no new op is accepted.
- Reset mid-MUL aborts the iteration. No partial result is ever presented.

## Configuration
- ALU_MUL_EN defined: MUL supported as above; err is always 0.
- ALU_MUL_EN undefined: no multiplier logic and no MUL state.
  - Op 111 completes in one cycle with result=0, result_hi=0, flag_z=1, other flags 0, err=1.
  - result_hi is tied to 0.

## Structure
- alu_pkg holds:
  - the op_t enum (3-bit codes above);
  - the state_t enum (IDLE, MUL);
  - localparam opcode constants reused by the decoder and testbench.
- Sub-module alu_mul_seq: iterative multiplier with start/done and a WIDTH-cycle counter. It is instantiated only under ALU_MUL_EN.
- All other datapath (logic, adder/subtractor, barrel shifter, flags) lives in alu_pipe.

## Test plan
All cases at WIDTH=8.
- ADD 0xFF+0x01 → result 0x00, c=1, z=1, n=0, v=0, one cycle after accept.
- SUB 0x80-0x01 → 0x7F, c=1, v=1. SUB 0x01-0x02 → 0xFF, c=0, n=1, v=0.
- SLL 0x81 by 1 → 0x02, c=1. SRL 0x81 by 3 → 0x10, c=0. AND 0xF0&0x3C → 0x30. OR → 0xFC. XOR → 0xCC.
- Back-pressure: issue ADD, OR back-to-back with out_ready=0 → first result held, in_ready=0. Raise out_ready → both results delivered in order, with no gap between them.
- MUL 0xFF×0xFF (ALU_MUL_EN) → hi 0xFE, lo 0x01, c=1, out_valid 8 cycles after accept, in_ready=0 throughout. Without the macro → err=1, result 0, latency 1.
- Assert rst_n low 3 cycles into MUL → all outputs 0 immediately. A new ADD after release completes normally.
